// File: rtl/fifo_burst_rd_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_burst_pkg                                                   |
// | Shared types and defaults for the FIFO burst read controller.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W       = 128;
  localparam int unsigned DEF_BURST_LEN    = 16;
  localparam int unsigned DEF_FRAME_BURSTS = 32400;

  function automatic int unsigned burst_addr_step(input int unsigned len, input int unsigned dw);
    return len * dw / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_burst_rd_ctrl_out_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | burst_out_buf                                                    |
// | 2-entry fall-through valid/ready buffer; reports its occupancy.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module burst_out_buf #(
  parameter int unsigned WIDTH = 129
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rptr;
  logic             r_wptr;
  logic [1:0]       r_cnt;
  logic             w_empty;
  logic             w_enq;
  logic             w_deq;

  // Input is never back-pressured: the parent only issues a read when a slot is guaranteed.
  assign w_empty   = (r_cnt == 2'd0);
  assign out_valid = !w_empty || in_valid;
  assign out_data  = !out_valid ? '0 : (w_empty ? in_data : r_mem[r_rptr]);
  assign w_deq     = !w_empty && out_ready;
  assign w_enq     = in_valid && !(w_empty && out_ready);
  assign occ       = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr <= 1'b0;
      r_wptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wptr] <= in_data;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_burst_rd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_burst_rd_ctrl                                               |
// | Pops fixed-length bursts from the pixel FIFO and streams them    |
// | to the DDR write arbiter. FIFO_BURST_FLUSH_EN enables a short    |
// | flush burst of residual words on frame_start.                    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fifo_burst_rd_ctrl
  import fifo_burst_pkg::*;
#(
  parameter int unsigned       DATA_W       = DEF_DATA_W,
  parameter int unsigned       LVL_W        = 6,
  parameter int unsigned       ADDR_W       = 28,
  parameter int unsigned       BURST_LEN    = DEF_BURST_LEN,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       FRAME_BURSTS = DEF_FRAME_BURSTS,
  parameter int unsigned       ADDR_STEP    = burst_addr_step(BURST_LEN, DATA_W)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              frame_start,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic [LVL_W-1:0]  fifo_rd_water_level,
  output logic              req,
  output logic [ADDR_W-1:0] req_addr,
  output logic [4:0]        req_len,
  input  logic              gnt,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  output logic              busy,
  output logic              underflow
);

  localparam int unsigned        IDX_W    = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_BURSTS - 1);
  localparam logic [4:0]         FULL_LEN = 5'(BURST_LEN);
  localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]  STEP     = ADDR_W'(ADDR_STEP);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [IDX_W-1:0]  r_idx;
  logic [4:0]        r_len;
  logic [4:0]        r_popped;
  logic              r_frame_pend;
  logic              r_underflow;
  logic              r_rd_pend;
  logic              r_rd_last;
  logic [1:0]        w_occ;
  logic              w_room;
  logic              w_pop;
  logic              w_starved;
  logic              w_done;
  logic              w_start_req;
  logic              w_apply_frame;
  logic              w_flush_ok;
  logic [4:0]        w_req_len;

`ifdef FIFO_BURST_FLUSH_EN
  logic r_flush_done;
  assign w_flush_ok = r_frame_pend && !r_flush_done &&
                      (fifo_rd_water_level != '0) && (fifo_rd_water_level < LVL_FULL);
`else
  assign w_flush_ok = 1'b0;
`endif

  // Reads in flight count against buffer space so returned data always has a slot.
  assign w_room    = ({1'b0, w_occ} + {2'b00, r_rd_pend}) < 3'd2;
  assign w_pop     = (r_state == DATA) && (r_popped < r_len) && w_room && !fifo_rd_empty;
  assign w_starved = (r_state == DATA) && (r_popped < r_len) && w_room && fifo_rd_empty;
  assign w_done    = (r_state == DATA) && wvalid && wready && wlast;

  always_comb begin
    w_state_nxt   = r_state;
    w_start_req   = 1'b0;
    w_apply_frame = 1'b0;
    w_req_len     = FULL_LEN;
    case (r_state)
      IDLE: begin
        if (w_flush_ok) begin
          w_start_req = 1'b1;
          w_req_len   = 5'(fifo_rd_water_level);
          w_state_nxt = REQ;
        end else if (r_frame_pend) begin
          w_apply_frame = 1'b1;
        end else if (fifo_rd_water_level >= LVL_FULL) begin
          w_start_req = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ:     if (gnt) w_state_nxt = DATA;
      DATA:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state      <= IDLE;
      r_addr       <= BASE_ADDR;
      r_idx        <= '0;
      r_len        <= '0;
      r_popped     <= '0;
      r_frame_pend <= 1'b0;
      r_underflow  <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_pop;
      r_rd_last <= w_pop && (r_popped == r_len - 5'd1);

      if (w_start_req) begin
        r_len    <= w_req_len;
        r_popped <= '0;
      end else if (w_pop) begin
        r_popped <= r_popped + 5'd1;
      end

      if (w_apply_frame) begin
        r_addr <= BASE_ADDR;
        r_idx  <= '0;
      end else if (w_done) begin
        if (r_idx == LAST_IDX) begin
          r_addr <= BASE_ADDR;
          r_idx  <= '0;
        end else begin
          r_addr <= r_addr + STEP;
          r_idx  <= r_idx + IDX_W'(1);
        end
      end

      // A fresh pulse wins over clearing so it is never lost.
      if (frame_start)        r_frame_pend <= 1'b1;
      else if (w_apply_frame) r_frame_pend <= 1'b0;

      if (w_starved) r_underflow <= 1'b1;
    end
  end

`ifdef FIFO_BURST_FLUSH_EN
  // Allows one short burst per pending frame restart.
  always_ff @(posedge rd_clk) begin
    if (rd_rst)             r_flush_done <= 1'b0;
    else if (w_apply_frame) r_flush_done <= 1'b0;
    else if (w_flush_ok)    r_flush_done <= 1'b1;
  end
`endif

  burst_out_buf #(
    .WIDTH (DATA_W + 1)
  ) u_out_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .in_valid  (r_rd_pend),
    .in_data   ({r_rd_last, fifo_rd_data}),
    .out_valid (wvalid),
    .out_data  ({wlast, wdata}),
    .out_ready (wready),
    .occ       (w_occ)
  );

  assign fifo_rd_en = w_pop;
  assign req        = (r_state == REQ);
  assign req_addr   = r_addr;
  assign req_len    = r_len;
  assign busy       = (r_state != IDLE);
  assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: doc/fifo_burst_rd_ctrl.md
Name: fifo_burst_rd_ctrl

Overview:
- Read-side controller for the 32-to-128-bit async pixel FIFO on the HDMI board.
- Watches the FIFO read water level and requests a fixed-length write burst from the DDR write arbiter when a full burst is buffered.
- After grant, it pops exactly that many 128-bit words and streams them on a valid/ready data channel with last marking.
- Generates frame-relative burst addresses that wrap at frame end.

Parameters:
- DATA_W, 128, FIFO read / output data width.
- LVL_W, 6, width of FIFO rd_water_level (FIFO read depth width 5, plus 1).
- ADDR_W, 28, byte address width.
- BURST_LEN, 16, words per burst; range 1..31.
- BASE_ADDR, 0, frame buffer byte base address.
- FRAME_BURSTS, 32400, bursts per frame (1920x1080x32b / 128b / 16).
- ADDR_STEP, BURST_LEN*DATA_W/8, byte address increment per burst.

Ports:
- rd_clk  in  1  FIFO read clock; sole clock.
- rd_rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse; restart addressing at BASE_ADDR.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_water_level  in  LVL_W  FIFO words available.
- req  out  1  burst request to arbiter.
- req_addr  out  ADDR_W  burst byte address.
- req_len  out  5  burst length in words.
- gnt  in  1  arbiter grant, single-cycle pulse.
- wdata  out  DATA_W  burst data.
- wvalid  out  1  wdata valid.
- wready  in  1  downstream accept.
- wlast  out  1  last word of burst.
- busy  out  1  state != IDLE.
- underflow  out  1  sticky; set if a pop is needed while FIFO is empty.

Behaviour:
- Reset values:
  - All outputs 0.
  - req_addr = BASE_ADDR; burst index = 0; state = IDLE.
  - Output buffer empty; pending-frame flag cleared.
- State IDLE:
  - If frame_pend, apply it: addr = BASE_ADDR, index = 0, clear frame_pend; stay in IDLE that cycle.
  - Else if fifo_rd_water_level >= BURST_LEN: go to REQ, req_len = BURST_LEN.
- State REQ:
  - req=1; req_addr and req_len held stable.
  - On gnt: req drops next cycle, go to DATA. Request-to-grant latency is unbounded.
- State DATA:
  - fifo_rd_en = 1 when popped < req_len, !fifo_rd_empty, and (buffer occupancy + in-flight reads) < 2.
  - Each read returns data one cycle later into a 2-entry output buffer.
  - wvalid = buffer non-empty. A word transfers when wvalid & wready.
  - wlast = 1 on the word where the sent count equals req_len-1.
  - If wvalid & !wready, wdata/wvalid/wlast are held stable.
  - The transfer with wlast completes the burst:
    - Go to IDLE.
    - If index == FRAME_BURSTS-1: addr = BASE_ADDR, index = 0.
    - Else addr += ADDR_STEP, index += 1.
- Throughput: 1 word/cycle with wready held high.
- Latency from gnt to first wvalid is 2 cycles: rd_en at gnt+1, data at gnt+2.
- frame_start:
  - Always sets frame_pend.
  - Applied only in IDLE, never mid-burst; the burst in progress completes at its original address.
  - frame_start arriving in the same cycle as burst completion is applied in the following IDLE cycle.
- Empty during DATA: no pop issued, stall, underflow set (sticky until rd_rst). Not expected, since the level is checked before REQ.
- Address arithmetic is modulo 2^ADDR_W.
- rd_rst mid-burst:
  - Returns to reset values the next cycle.
  - Any in-flight FIFO read data is discarded.
  - No wlast is generated.

Optional Feature:
- FIFO_BURST_FLUSH_EN defined:
  - In IDLE with frame_pend set and 0 < level < BURST_LEN, issue a short burst first: req_len = level, at the current address.
  - frame_pend is applied after that burst completes.
- Not defined:
  - Residual words stay in the FIFO and lead the next frame.
  - req_len is constant BURST_LEN.

Decomposition:
- Package fifo_burst_pkg:
  - State enum {IDLE, REQ, DATA}.
  - Default DATA_W, BURST_LEN, FRAME_BURSTS constants.
  - Function computing ADDR_STEP.
- Sub-module burst_out_buf: a 2-entry valid/ready buffer carrying {wlast, wdata}. It reports occupancy to the parent for rd_en gating.

Test Plan:
- Level=16, gnt 3 cycles after req, wready=1:
  - req_addr=0, req_len=16.
  - 16 words in order, wlast on word 16.
  - Next req_addr=256.
- Level stays 15:
  - req never asserts, busy=0.
  - Level 16 -> req the next cycle.
- wready toggling 1/0 every cycle during DATA:
  - No word lost or duplicated; wdata stable while stalled.
  - Exactly 16 transfers.
- FRAME_BURSTS=3 run 4 bursts:
  - Addresses 0, 256, 512, 0.
- frame_start pulse at word 8 of burst at 512:
  - Burst finishes at 512.
  - Next req_addr=0.
- rd_rst at word 5:
  - Next cycle: wvalid=0, req=0, req_addr=BASE_ADDR.
  - With FIFO_BURST_FLUSH_EN, level=5 plus frame_start gives req_len=5 before the address resets.
